// File: rtl/timer_cmd_sequencer_if.sv
// Command handshake and Avalon-MM timer register port shared by the sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the command source and timer side.
interface timer_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        input  cmd_valid, cmd_op, cmd_period, cmd_continuous, tmr_readdata, tmr_irq,
        output cmd_ready, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_period, cmd_continuous, tmr_readdata, tmr_irq,
        input  cmd_ready, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
    );
endinterface

// File: rtl/timer_cmd_sequencer.sv
// Expands start/stop/snapshot commands into interval-timer register accesses and services the
// timer irq (status clear, tick pulse, tick counter) without software involvement.
module timer_cmd_sequencer #(
    parameter int TICK_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    timer_cmd_sequencer_if.master bus,
    output logic                  running,
    output logic                  busy,
    output logic                  tick,
    output logic [TICK_W-1:0]     tick_count,
    output logic                  snap_valid,
    output logic [31:0]           snap_value
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_STOP, ST_WR_PL, ST_WR_PH, ST_WR_CLR, ST_WR_CTRL, ST_ARMED,
        ST_WR_SNAP, ST_RD_SL, ST_RD_SH, ST_RD_DONE, ST_ACK_IRQ, ST_ACK_HOLD
    } state_t;

    state_t      state_r, state_nx_s;
    logic [31:0] period_r;
    logic        cont_r, stopping_r, snap_armed_r;
    logic        ready_idle_r, ready_armed_r;
    logic        accept_s;
    logic        cs_nx_s, wr_n_nx_s;
    logic [2:0]  addr_nx_s;
    logic [15:0] data_nx_s;

    // The irq gate stays combinational so a rising irq in ARMED wins over a command in the same cycle.
    assign bus.cmd_ready = ready_idle_r | (ready_armed_r & ~bus.tmr_irq);
    assign accept_s      = bus.cmd_valid & bus.cmd_ready;

    // Next-state selection.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_ARMED: begin
                if (state_r == ST_ARMED && bus.tmr_irq) begin
                    state_nx_s = ST_ACK_IRQ;
                end else if (accept_s) begin
                    case (bus.cmd_op)
                        2'd0, 2'd1: state_nx_s = ST_WR_STOP;
                        2'd2:       state_nx_s = ST_WR_SNAP;
                        default:    state_nx_s = state_r;
                    endcase
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_WR_STOP:  state_nx_s = stopping_r ? ST_IDLE : ST_WR_PL;
            ST_WR_PL:    state_nx_s = ST_WR_PH;
            ST_WR_PH:    state_nx_s = ST_WR_CLR;
            ST_WR_CLR:   state_nx_s = ST_WR_CTRL;
            ST_WR_CTRL:  state_nx_s = ST_ARMED;
            ST_WR_SNAP:  state_nx_s = ST_RD_SL;
            ST_RD_SL:    state_nx_s = ST_RD_SH;
            ST_RD_SH:    state_nx_s = ST_RD_DONE;
            ST_RD_DONE:  state_nx_s = snap_armed_r ? ST_ARMED : ST_IDLE;
            ST_ACK_IRQ:  state_nx_s = ST_ACK_HOLD;
            ST_ACK_HOLD: state_nx_s = cont_r ? ST_ARMED : ST_IDLE;
            default:     state_nx_s = ST_IDLE;
        endcase
    end

    // Bus access decoded from the state being entered, so it is registered alongside it.
    always_comb begin
        cs_nx_s   = 1'b1;
        wr_n_nx_s = 1'b0;
        addr_nx_s = 3'd0;
        data_nx_s = 16'h0000;
        case (state_nx_s)
            ST_WR_STOP: begin addr_nx_s = 3'd1; data_nx_s = 16'h0008; end
            ST_WR_PL:   begin addr_nx_s = 3'd2; data_nx_s = period_r[15:0]; end
            ST_WR_PH:   begin addr_nx_s = 3'd3; data_nx_s = period_r[31:16]; end
            ST_WR_CLR:  addr_nx_s = 3'd0;
            ST_WR_CTRL: begin addr_nx_s = 3'd1; data_nx_s = {13'd0, 1'b1, cont_r, 1'b1}; end
            ST_WR_SNAP: addr_nx_s = 3'd4;
            ST_RD_SL:   begin addr_nx_s = 3'd4; wr_n_nx_s = 1'b1; end
            ST_RD_SH:   begin addr_nx_s = 3'd5; wr_n_nx_s = 1'b1; end
            ST_ACK_IRQ: addr_nx_s = 3'd0;
            default:    begin cs_nx_s = 1'b0; wr_n_nx_s = 1'b1; end
        endcase
    end

    // State, bus and handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r            <= ST_IDLE;
            bus.tmr_chipselect <= 1'b0;
            bus.tmr_write_n    <= 1'b1;
            bus.tmr_address    <= 3'd0;
            bus.tmr_writedata  <= 16'h0000;
            ready_idle_r       <= 1'b0;
            ready_armed_r      <= 1'b0;
        end else begin
            state_r            <= state_nx_s;
            bus.tmr_chipselect <= cs_nx_s;
            bus.tmr_write_n    <= wr_n_nx_s;
            bus.tmr_address    <= addr_nx_s;
            bus.tmr_writedata  <= data_nx_s;
            ready_idle_r       <= (state_nx_s == ST_IDLE);
            ready_armed_r      <= (state_nx_s == ST_ARMED);
        end
    end

    // Command context latched on acceptance; a zero period would never expire, so it becomes 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_r     <= 32'd0;
            cont_r       <= 1'b0;
            stopping_r   <= 1'b0;
            snap_armed_r <= 1'b0;
        end else if (accept_s && state_nx_s != ST_ACK_IRQ) begin
            if (bus.cmd_op == 2'd0) begin
                period_r <= (bus.cmd_period == 32'd0) ? 32'd1 : bus.cmd_period;
                cont_r   <= bus.cmd_continuous;
            end else begin
                period_r <= period_r;
                cont_r   <= cont_r;
            end
            stopping_r   <= (bus.cmd_op == 2'd1);
            snap_armed_r <= (state_r == ST_ARMED);
        end else begin
            period_r     <= period_r;
        end
    end

    // Status outputs and tick accounting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running    <= 1'b0;
            busy       <= 1'b0;
            tick       <= 1'b0;
            tick_count <= '0;
        end else begin
            if (state_nx_s == ST_ARMED) begin
                running <= 1'b1;
            end else if (state_nx_s == ST_IDLE) begin
                running <= 1'b0;
            end else begin
                running <= running;
            end
            busy <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_ARMED);
            tick <= (state_nx_s == ST_ACK_IRQ);
            if (state_nx_s == ST_ACK_IRQ) begin
                tick_count <= tick_count + {{(TICK_W-1){1'b0}}, 1'b1};
            end else if (accept_s && bus.cmd_op == 2'd0) begin
                tick_count <= '0;
            end else begin
                tick_count <= tick_count;
            end
        end
    end

    // Read data lags the address by one cycle, so each half is taken in the state after its read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_value <= 32'd0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= (state_r == ST_RD_DONE);
            if (state_r == ST_RD_SH) begin
                snap_value[15:0] <= bus.tmr_readdata;
            end else if (state_r == ST_RD_DONE) begin
                snap_value[31:16] <= bus.tmr_readdata;
            end else begin
                snap_value <= snap_value;
            end
        end
    end

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Directed bench: expected timer bus accesses are queued as commands are issued and checked as they appear.
module tb_timer_cmd_sequencer;
    localparam int TICK_W = 16;

    typedef struct {
        logic [19:0] acc;   // {write_n, address, writedata (0 on reads)}
        int          cyc;   // -1 when the exact cycle is not pinned
    } bus_exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              running, busy, tick, snap_valid;
    logic [TICK_W-1:0] tick_count;
    logic [31:0]       snap_value;
    logic [15:0]       snap_lo = 16'h0000;
    logic [15:0]       snap_hi = 16'h0000;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                n;
    bus_exp_t          sb[$];

    timer_cmd_sequencer_if bus ();

    timer_cmd_sequencer #(.TICK_W(TICK_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .running    (running),
        .busy       (busy),
        .tick       (tick),
        .tick_count (tick_count),
        .snap_valid (snap_valid),
        .snap_value (snap_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered timer read port: data for the presented address appears the following cycle.
    always @(posedge clk)
        bus.tmr_readdata <= (bus.tmr_address == 3'd4) ? snap_lo :
                            (bus.tmr_address == 3'd5) ? snap_hi : 16'h0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [2:0] a, input logic [15:0] d, input int c);
        bus_exp_t e;
        e.acc = {~wr, a, wr ? d : 16'h0000};
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Every bus access must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && bus.tmr_chipselect) begin
            if (sb.size() == 0) begin
                chk("unexpected_access", {bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata}, 20'hFFFFF);
            end else begin
                bus_exp_t e;
                e = sb.pop_front();
                chk("bus_access", {bus.tmr_write_n, bus.tmr_address,
                                   bus.tmr_write_n ? 16'h0000 : bus.tmr_writedata}, e.acc);
                if (e.cyc >= 0) chk("bus_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one command; returns the cycle number following the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] per, input logic cont, output int acc);
        int w;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_period = per; bus.cmd_continuous = cont;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("cmd_accept_timeout", w, 0);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_start(input int c, input logic [15:0] pl, input logic [15:0] ph, input logic [15:0] ctl);
        push(1'b1, 3'd1, 16'h0008, c);
        push(1'b1, 3'd2, pl, c + 1);
        push(1'b1, 3'd3, ph, c + 2);
        push(1'b1, 3'd0, 16'h0000, c + 3);
        push(1'b1, 3'd1, ctl, c + 4);
    endtask

    // Raise irq and wait (bounded) for the status-clear write; leaves the bench in the ACK cycle.
    task automatic irq_to_ack(input logic [TICK_W-1:0] exp_cnt);
        int w;
        @(negedge clk);
        bus.tmr_irq = 1'b1;
        push(1'b1, 3'd0, 16'h0000, -1);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd0) && w < 20);
        if (w >= 20) chk("ack_timeout", w, 0);
        chk("tick_on_ack", tick, 1'b1);
        chk("tick_count", tick_count, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_period = 32'd0;
        bus.cmd_continuous = 1'b0; bus.tmr_irq = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata,
                            running, busy, tick, snap_valid, bus.cmd_ready},
                           {1'b0, 1'b1, 3'd0, 16'h0000, 5'b00000});
        chk("rst_values", {tick_count, snap_value}, 48'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", bus.cmd_ready, 1'b1);

        // Continuous start: five writes on consecutive cycles, ARMED on the sixth.
        send(2'd0, 32'h0001_86A0, 1'b1, n);
        push_start(n, 16'h86A0, 16'h0001, 16'h0007);
        @(negedge clk);
        chk("start_busy", {busy, running}, 2'b10);
        repeat (5) @(negedge clk);
        chk("armed", {running, busy, bus.cmd_ready}, 3'b101);

        // Three timeouts, irq held one cycle past the clear.
        for (int k = 1; k <= 3; k++) begin
            repeat (3) @(negedge clk);
            irq_to_ack(k[TICK_W-1:0]);
            @(negedge clk);
            chk("tick_pulse_end", tick, 1'b0);
            @(negedge clk);
            bus.tmr_irq = 1'b0;
            chk("periodic_running", {running, busy}, 2'b10);
        end

        // Snapshot from ARMED.
        snap_lo = 16'h3456; snap_hi = 16'h0012;
        send(2'd2, 32'd0, 1'b0, n);
        push(1'b1, 3'd4, 16'h0000, n);
        push(1'b0, 3'd4, 16'h0000, n + 1);
        push(1'b0, 3'd5, 16'h0000, n + 2);
        repeat (5) @(negedge clk);
        chk("snap_valid", snap_valid, 1'b1);
        chk("snap_value", snap_value, 32'h0012_3456);
        chk("snap_back_armed", {running, busy}, 2'b10);
        @(negedge clk);
        chk("snap_valid_pulse", snap_valid, 1'b0);

        // irq and stop in the same ARMED cycle: irq is serviced first.
        bus.tmr_irq = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1;
        #1;
        chk("irq_blocks_ready", bus.cmd_ready, 1'b0);
        push(1'b1, 3'd0, 16'h0000, -1);
        push(1'b1, 3'd1, 16'h0008, -1);
        @(negedge clk);
        chk("irq_first_tick", {tick, tick_count}, {1'b1, 16'd4});
        repeat (2) @(negedge clk);
        bus.tmr_irq = 1'b0;
        #1;
        chk("ready_after_hold", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stopped", {running, busy, bus.cmd_ready}, 3'b001);

        // One-shot start, period 9.
        send(2'd0, 32'd9, 1'b0, n);
        push_start(n, 16'h0009, 16'h0000, 16'h0005);
        repeat (6) @(negedge clk);
        chk("oneshot_armed", running, 1'b1);
        irq_to_ack(16'd1);
        repeat (2) @(negedge clk);
        chk("oneshot_idle", {running, busy, bus.cmd_ready}, 3'b001);
        bus.tmr_irq = 1'b0;

        // Reset asserted during WR_PH.
        send(2'd0, 32'h0005_0003, 1'b1, n);
        push(1'b1, 3'd1, 16'h0008, n);
        push(1'b1, 3'd2, 16'h0003, n + 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midseq_rst_bus", {bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata},
                              {1'b0, 1'b1, 3'd0, 16'h0000});
        chk("midseq_rst_status", {running, busy, tick, snap_valid, bus.cmd_ready, tick_count},
                                 {5'b00000, 16'd0});
        chk("midseq_queue", sb.size(), 0);
        reset = 1'b0;

        // Restart with period 0 after the reset.
        send(2'd0, 32'd0, 1'b0, n);
        push_start(n, 16'h0001, 16'h0000, 16'h0005);
        repeat (6) @(negedge clk);
        chk("restart_armed", {running, busy}, 2'b10);

        // Reserved op: accepted, no access, state unchanged.
        send(2'd3, 32'd0, 1'b0, n);
        @(negedge clk);
        chk("reserved_noop", {running, busy, bus.cmd_ready}, 3'b101);
        repeat (4) @(negedge clk);
        chk("queue_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_cmd_sequencer.md
Name: timer_cmd_sequencer

Overview:
Avalon-MM master sequencer that owns the 16-bit register port of the system interval timer (status/control/period_l/period_h/snap_l/snap_h at word addresses 0-5). It accepts one-word commands (start, stop, snapshot) from fabric logic and expands each into the required register write and read sequence. It services the timer irq by clearing status, counting ticks and emitting a tick pulse, so hardware clients can use the timer without a Nios driver.

Parameters:
TICK_W, 16, width of tick_count (wraps modulo 2^TICK_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge
cmd_op  in  2  0=start, 1=stop, 2=snapshot, 3=reserved (accepted, no-op)
cmd_period  in  32  timer period in clocks minus one; sampled on start accept
cmd_continuous  in  1  1=periodic, 0=one-shot; sampled on start accept
running  out  1  a start sequence has completed and no stop/one-shot expiry has followed
busy  out  1  FSM is not in IDLE or ARMED
tick  out  1  one-cycle pulse per serviced timeout
tick_count  out  TICK_W  timeouts since last start
snap_valid  out  1  one-cycle pulse, snap_value updated
snap_value  out  32  captured counter snapshot
tmr_address  out  3  timer word address
tmr_chipselect  out  1  timer select
tmr_write_n  out  1  active-low write
tmr_writedata  out  16  write data
tmr_readdata  in  16  timer read data, registered: valid the cycle after the address is presented
tmr_irq  in  1  timer interrupt (level)

Behaviour:
- Reset: state IDLE; tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0; running=0, busy=0, tick=0, snap_valid=0, tick_count=0, snap_value=0, cmd_ready=0 during reset. All outputs are registered.
- Bus rule: exactly one access per bus state. The access is a single cycle with chipselect=1; there is no waitrequest. In non-bus states chipselect=0 and write_n=1.
- cmd_ready=1 in IDLE, and in ARMED when tmr_irq=0; 0 otherwise. In ARMED, irq takes priority over a simultaneous command.
- Start sequence, 1 cycle per state:
  - WR_STOP: addr1 <- 0x0008
  - WR_PL: addr2 <- period[15:0]
  - WR_PH: addr3 <- period[31:16]
  - WR_CLR: addr0 <- 0x0000
  - WR_CTRL: addr1 <- 0x0004 | (cont<<1) | 0x0001
  - then ARMED with running=1.
  - Accept at cycle 0 gives the first write at cycle 1 and ARMED at cycle 6.
  - tick_count clears on accept. cmd_period==0 is replaced by 1.
- Start while ARMED restarts via the full sequence.
- Stop: WR_STOP (addr1 <- 0x0008), then IDLE; running=0. Stop from IDLE is legal and performs the same write.
- Snapshot:
  - WR_SNAP: addr4 <- 0x0000
  - RD_SL: read addr4
  - RD_SH: read addr5, capture snap_value[15:0]
  - RD_DONE: no access; capture snap_value[31:16]; snap_valid=1
  - Return to the origin state (IDLE or ARMED), with running unchanged.
- IRQ service, in ARMED when tmr_irq=1:
  - ACK_IRQ: addr0 <- 0x0000; tick=1; tick_count+1 (wraps).
  - ACK_HOLD: no access; tmr_irq is ignored while the status clear propagates.
  - Then ARMED if continuous. If one-shot, go to IDLE with running=0.
- tmr_irq is ignored in all states except ARMED.
- Reserved op is accepted and the FSM stays in its current state.
- Reset mid-sequence: the FSM returns to IDLE immediately and the bus is released. Timer registers are not rewritten.

Test Plan:
- Start, period 0x0001_86A0, continuous -> writes (1,0x0008),(2,0x86A0),(3,0x0001),(0,0x0000),(1,0x0007) on consecutive cycles 1-5; running=1 at cycle 6.
- Timer model raises irq; hold irq 1 cycle past the clear -> exactly one ACK write and one tick per timeout; tick_count steps 1,2,3 over three periods.
- One-shot start, period 9 -> control write 0x0005; after the first irq: one tick, running=0, IDLE, cmd_ready=1.
- Snapshot in ARMED with the model counter at 0x0012_3456 -> write addr4, reads addr4/addr5; snap_value=0x0012_3456 with snap_valid; back in ARMED, running=1.
- irq and stop command in the same ARMED cycle -> cmd_ready=0; ACK/ACK_HOLD first; stop accepted after; control write 0x0008; running=0.
- Assert reset during WR_PH -> chipselect=0 on that cycle, all outputs at reset values; a following start re-runs the full 5-write sequence; start with period 0 writes period_l=0x0001.
